// File: rtl/dmrw_unit.sv
// DMRW-stage data-memory responder: performs RV32I loads/stores one byte per
// cycle over a byte-wide synchronous memory and returns extended load data.
module dmrw_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_stat_dmrw,
  input  logic              dm_load,
  input  logic              dm_store,
  input  logic [2:0]        dm_funct3,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dmrw_run,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, COLLECT} state_e;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 3'd1;
      3'b001, 3'b101: return 3'd2;
      default:        return 3'd4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      3'd2:    return a[0];
      3'd4:    return |a;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'b0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'b0, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;
  logic              run_q, run_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              start, access0, mis0, go0;
  logic [2:0]        size0, cur_size, cnt_nxt;
  logic [1:0]        asm_idx;
  logic [31:0]       asm_in;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^dm_addr[31:ADDR_W];

  // Cycle-0 decode works straight off the dm_* inputs.
  assign start    = (state_q == IDLE) && cpu_stat_dmrw;
  assign access0  = dm_load || dm_store;
  assign size0    = size_of(dm_funct3);
  assign mis0     = misaligned(dm_funct3, dm_addr[1:0]);
  assign go0      = start && access0 && !mis0;
  assign cur_size = size_of(f3_q);
  assign cnt_nxt  = cnt_q + 3'd1;
  assign asm_idx  = 2'(cnt_q - 3'd1);

  // The byte arriving this cycle is merged before being stored or extended.
  always_comb begin
    asm_in = asm_q;
    asm_in[{asm_idx, 3'b000} +: 8] = mem_rdata;
  end

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    load_d      = load_q;
    store_d     = store_q;
    asm_d       = asm_q;
    ld_data_d   = ld_data_q;
    ld_valid_d  = 1'b0;
    run_d       = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = dm_addr[ADDR_W-1:0];
          wdata_d = dm_wdata;
          f3_d    = dm_funct3;
          load_d  = dm_load;
          store_d = dm_store;
        end
        if (go0) begin
          if (dm_load && size0 == 3'd1) begin
            state_d = COLLECT;
            cnt_d   = 3'd1;
          end else if (!(dm_store && size0 == 3'd1)) begin
            state_d     = XFER;
            cnt_d       = 3'd1;
            mem_re_d    = dm_load;
            mem_we_d    = dm_store;
            mem_addr_d  = dm_addr[ADDR_W-1:0] + ADDR_W'(1);
            mem_wdata_d = byte_of(dm_wdata, 2'd1);
            run_d       = dm_load || (size0 > 3'd2);
          end
        end
      end

      XFER: begin
        if (!cpu_stat_dmrw) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (load_q) asm_d = asm_in;
          if (cnt_q == cur_size - 3'd1) begin
            state_d = load_q ? COLLECT : IDLE;
            cnt_d   = load_q ? cnt_nxt : 3'd0;
          end else begin
            cnt_d       = cnt_nxt;
            mem_re_d    = load_q;
            mem_we_d    = store_q;
            mem_addr_d  = addr_q + ADDR_W'(cnt_nxt);
            mem_wdata_d = byte_of(wdata_q, cnt_nxt[1:0]);
            run_d       = load_q || (cnt_nxt < cur_size - 3'd1);
          end
        end
      end

      COLLECT: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        if (cpu_stat_dmrw) begin
          ld_data_d  = extend(f3_q, asm_in);
          ld_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // First byte issues combinationally; strobes are gated so an abort or a
  // reset removes them within the same cycle.
  always_comb begin
    dmrw_run     = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    misalign_err = 1'b0;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (state_q == IDLE) begin
      misalign_err = start && access0 && mis0;
      if (go0) begin
        dmrw_run  = dm_load || (size0 != 3'd1);
        mem_re    = dm_load;
        mem_we    = dm_store;
        mem_addr  = dm_addr[ADDR_W-1:0];
        mem_wdata = dm_wdata[7:0];
      end
    end else begin
      dmrw_run = run_q && cpu_stat_dmrw;
      mem_re   = mem_re_q && cpu_stat_dmrw;
      mem_we   = mem_we_q && cpu_stat_dmrw;
    end
  end

  assign ld_data  = ld_data_q;
  assign ld_valid = ld_valid_q;

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= 3'd0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      asm_q       <= '0;
      ld_data_q   <= '0;
      ld_valid_q  <= 1'b0;
      run_q       <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      load_q      <= load_d;
      store_q     <= store_d;
      asm_q       <= asm_d;
      ld_data_q   <= ld_data_d;
      ld_valid_q  <= ld_valid_d;
      run_q       <= run_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: doc/dmrw_unit.md
Name: dmrw_unit

Overview:
- Data-memory access responder for the multi-cycle RV32I core. It serves the CPU sequencer's DMRW stage.
- When the sequencer asserts cpu_stat_dmrw, the unit performs the load or store over a byte-wide synchronous data memory.
- It holds dmrw_run high while more cycles are needed and deasserts it in the final cycle, so the sequencer leaves DMRW exactly when the access completes.
- Load results are returned sign- or zero-extended for register writeback.

Parameters:
ADDR_W, 16, byte-address width of the data memory port; upper dm_addr bits are ignored.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cpu_stat_dmrw  input  1  sequencer is in the DMRW state
dm_load  input  1  current instruction is a load
dm_store  input  1  current instruction is a store; never asserted together with dm_load
dm_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
dm_addr  input  32  effective byte address
dm_wdata  input  32  store data from rs2
dmrw_run  output  1  access needs further cycles; sequencer stays in DMRW
ld_data  output  32  extended load result
ld_valid  output  1  one-cycle pulse when ld_data is updated
misalign_err  output  1  one-cycle pulse on a misaligned access
mem_addr  output  ADDR_W  byte address to data memory
mem_re  output  1  read strobe; data returned on mem_rdata the next cycle
mem_we  output  1  byte write strobe
mem_wdata  output  8  write byte
mem_rdata  input  8  read byte, 1-cycle latency after mem_re

Behaviour:
- Reset (async, active-high): state=IDLE; byte counter=0; dmrw_run=0; mem_re=0; mem_we=0; mem_addr=0; mem_wdata=0; ld_data=0; ld_valid=0; misalign_err=0.
- Size N: 1 for B/BU, 2 for H/HU, 4 for W. funct3 values 011, 110 and 111 are treated as W.
- Alignment: H/HU requires addr[0]=0. W requires addr[1:0]=0.
- Start cycle (cycle 0): state=IDLE and cpu_stat_dmrw=1. Latch dm_addr, dm_wdata, dm_funct3, dm_load and dm_store into registers. Later cycles use only the latched copies.
- No access (dm_load=dm_store=0): dmrw_run=0, no memory strobes, state stays IDLE. The sequencer spends one cycle in DMRW.
- Misaligned access: dmrw_run=0, no memory strobes, misalign_err=1 for that cycle, state stays IDLE. ld_data is unchanged and ld_valid=0.
- Combinational issue: memory outputs in cycle 0 are driven combinationally from dm_* so the first byte issues with no wait. From cycle 1 onward they are registered from the latched copies.
- Store, cycle k (k=0..N-1):
  - mem_we=1, mem_addr=addr+k, mem_wdata=wdata byte k (little-endian, byte 0 = bits 7:0).
  - dmrw_run = (k < N-1).
  - State XFER while k < N-1; returns to IDLE after cycle N-1.
  - SB completes in cycle 0 with dmrw_run=0.
- Load, cycles 0..N-1: mem_re=1, mem_addr=addr+k. Byte k arrives on mem_rdata in cycle k+1 and is captured into an internal assembly register.
- Load, final cycle N: no strobe, dmrw_run=0, state COLLECT.
  - At the end of cycle N, ld_data is loaded with the assembled value: sign-extended for B/H, zero-extended for BU/HU, full word for W.
  - ld_valid=1 during cycle N+1; state returns to IDLE.
- Load timing: dmrw_run is high for cycles 0..N-1, so a load spans N+1 DMRW cycles and a store spans N. ld_data holds until the next load completes.
- Address arithmetic: addr+k is computed modulo 2^ADDR_W and wraps at the top of memory.
- Early exit: if cpu_stat_dmrw drops while state is not IDLE, the unit aborts to IDLE next cycle. Strobes go to 0 immediately (combinationally gated by cpu_stat_dmrw), and ld_valid is not asserted. The stall input does not affect the DMRW stage, so the unit has no stall port.
- Reset mid-access: mem_re and mem_we drop immediately (asynchronously). No partial load result is produced.
- Back-to-back: a new start is recognised only in IDLE. A second DMRW visit may begin in the cycle after IDLE is re-entered.

Test Plan:
- SW addr 0x0100, wdata 0x11223344 -> mem_we for 4 cycles, writing 0x44@0x100, 0x33@0x101, 0x22@0x102, 0x11@0x103; dmrw_run=1,1,1,0; no ld_valid.
- LB addr 0x0005, memory byte 0x80 -> mem_re one cycle; dmrw_run=1,0; ld_data=0xFFFFFF80 with ld_valid in the following cycle. Repeat as LBU -> 0x00000080.
- LHU addr 0x0010, bytes 0x01,0x80 -> ld_data=0x00008001. LH with the same bytes -> 0xFFFF8001. dmrw_run=1,1,0.
- LW addr 0x0102 (misaligned) -> misalign_err pulse, dmrw_run=0, no mem_re, ld_data unchanged. SH at 0x0003 -> same response with no mem_we.
- Non-memory instruction in DMRW (dm_load=dm_store=0) -> dmrw_run=0, no strobes. LW at 0xFFFC with ADDR_W=16 -> addresses 0xFFFC..0xFFFF, then a LW at 0xFFFE is flagged misaligned.
- Assert rst in cycle 2 of a LW -> mem_re=0 immediately, all outputs at reset values, ld_valid never pulses. A following SB after reset release completes normally.
